// File: rtl/ram_mport_if.sv
// Bundle of the write port, NUM_RD read ports and the clear-engine status.
// Latency: wiring only, no state.
// Backpressure: none; the host watches init_busy before issuing requests.
interface ram_mport_if #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 8,
   parameter int NUM_RD     = 2
);
   localparam int STRB_W = DATA_WIDTH / 8;

   logic                           write_enable;
   logic [ADDR_WIDTH-1:0]          w_addr;
   logic [DATA_WIDTH-1:0]          w_data;
   logic [STRB_W-1:0]              w_strb;
   logic [NUM_RD-1:0]              r_en;
   logic [NUM_RD*ADDR_WIDTH-1:0]   r_addr;
   logic [NUM_RD*DATA_WIDTH-1:0]   r_data;
   logic [NUM_RD-1:0]              r_valid;
   logic                           init_busy;

   modport master (
      output write_enable, w_addr, w_data, w_strb, r_en, r_addr,
      input  r_data, r_valid, init_busy
   );

   modport slave (
      input  write_enable, w_addr, w_data, w_strb, r_en, r_addr,
      output r_data, r_valid, init_busy
   );
endinterface

// File: rtl/ram_mport.sv
// Multi-port scratch RAM: one byte-strobed write port, NUM_RD registered read ports, zeroed after reset.
// Latency: 1 cycle write and read; clear takes DEPTH cycles after reset release.
// Backpressure: none; requests while init_busy=1 are dropped. RAM_BYPASS_EN selects write-first forwarding.
module ram_mport #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 8,   // multiple of 8
   parameter int NUM_RD     = 2    // 1..8
) (
   input logic        clk,
   input logic        rst_n,
   ram_mport_if.slave bus
);
   localparam int DEPTH  = 2 ** ADDR_WIDTH;
   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int CW     = ADDR_WIDTH + 1;

   typedef enum logic {CLEAR, READY} state_t;

   state_t                       state_q, state_d;
   logic [CW-1:0]                cnt_q, cnt_d;
   logic                         clr_we;
   logic                         ready;
   logic                         wr_acc;
   logic [DATA_WIDTH-1:0]        mem [DEPTH];
   logic [DATA_WIDTH-1:0]        rd_d [NUM_RD];
   logic [NUM_RD*DATA_WIDTH-1:0] rd_q;
   logic [NUM_RD-1:0]            vld_q;

   assign ready         = (state_q == READY);
   assign wr_acc        = ready & bus.write_enable;
   assign bus.init_busy = (state_q == CLEAR);
   assign bus.r_data    = rd_q;
   assign bus.r_valid   = vld_q;

   // State and clear counter; reset always restarts the sweep from address 0
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Clear sweep: one zero word per cycle, leave CLEAR on the edge that writes DEPTH-1
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clr_we  = 1'b0;
      if (state_q == CLEAR) begin
         clr_we = 1'b1;
         cnt_d  = cnt_q + CW'(1);
         if (cnt_q == CW'(DEPTH - 1)) begin
            state_d = READY;
         end
      end
   end

   // Storage: clear-engine writes take priority; host writes only land in READY
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (clr_we) begin
            mem[cnt_q[ADDR_WIDTH-1:0]] <= '0;
         end else if (wr_acc) begin
            for (int i = 0; i < STRB_W; i++) begin
               if (bus.w_strb[i]) begin
                  mem[bus.w_addr][8*i +: 8] <= bus.w_data[8*i +: 8];
               end
            end
         end
      end
   end

`ifdef RAM_BYPASS_EN
   logic [DATA_WIDTH-1:0] wmask;

   // Expand byte strobes to a bit mask for merging forwarded write data
   always_comb begin
      wmask = '0;
      for (int i = 0; i < STRB_W; i++) begin
         wmask[8*i +: 8] = {8{bus.w_strb[i]}};
      end
   end
`endif

   // Per-port read word; with forwarding, a same-address write is merged in byte-wise
   always_comb begin
      for (int p = 0; p < NUM_RD; p++) begin
         rd_d[p] = mem[bus.r_addr[p*ADDR_WIDTH +: ADDR_WIDTH]];
`ifdef RAM_BYPASS_EN
         if (wr_acc && (bus.w_addr == bus.r_addr[p*ADDR_WIDTH +: ADDR_WIDTH])) begin
            rd_d[p] = (rd_d[p] & ~wmask) | (bus.w_data & wmask);
         end
`endif
      end
   end

   // Read registers: load on accepted r_en, otherwise hold data and drop valid
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_q  <= '0;
         vld_q <= '0;
      end else begin
         for (int p = 0; p < NUM_RD; p++) begin
            vld_q[p] <= ready & bus.r_en[p];
            if (ready && bus.r_en[p]) begin
               rd_q[p*DATA_WIDTH +: DATA_WIDTH] <= rd_d[p];
            end
         end
      end
   end
endmodule

// File: tb/tb_ram_mport.sv
// Directed self-checking bench for ram_mport with 3-bit address, 32-bit words, 4 read ports.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
// Expected values are hand-computed constants; forwarding expectations follow RAM_BYPASS_EN.
module tb_ram_mport;
   localparam int AW = 3;
   localparam int DW = 32;
   localparam int NR = 4;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   ram_mport_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR)) bus_if ();

   ram_mport #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus_if.write_enable = 1'b0;
      bus_if.w_addr       = '0;
      bus_if.w_data       = '0;
      bus_if.w_strb       = '0;
      bus_if.r_en         = '0;
      bus_if.r_addr       = '0;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
      bus_if.write_enable = 1'b1;
      bus_if.w_addr       = a;
      bus_if.w_data       = d;
      bus_if.w_strb       = s;
      tick();
      bus_if.write_enable = 1'b0;
   endtask

   // Count cycles until init_busy drops while requests are held active; nothing may reach the outputs
   task automatic wait_clear(input string tag);
      int n;
      n = 0;
      bus_if.write_enable = 1'b1;
      bus_if.w_addr       = 3'd0;
      bus_if.w_data       = 32'hFFFF_FFFF;
      bus_if.w_strb       = 4'hF;
      bus_if.r_en         = 4'hF;
      bus_if.r_addr       = '0;
      while (bus_if.init_busy === 1'b1 && n < 20) begin
         tick();
         n++;
         checks++;
         if (bus_if.r_valid !== 4'h0 || bus_if.r_data !== '0) begin
            errors++;
            $display("FAIL %s_quiet cycle %0d: r_valid=%h r_data=%h, required 0 and 0", tag, n, bus_if.r_valid, bus_if.r_data);
         end
      end
      idle();
      checks++;
      if (n !== 8) begin
         errors++;
         $display("FAIL %s_busy_cycles: got %0d, required 8", tag, n);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      tick();
      tick();
      checks++;
      if (bus_if.init_busy !== 1'b1 || bus_if.r_valid !== 4'h0 || bus_if.r_data !== '0) begin
         errors++;
         $display("FAIL reset_state: busy=%b r_valid=%h r_data=%h, required 1 0 0", bus_if.init_busy, bus_if.r_valid, bus_if.r_data);
      end
   endtask

   task automatic test_clear();
      rst_n = 1'b1;
      wait_clear("clear");
      // Every word, including address 0 written during clear, must read back zero on all ports
      for (int a = 0; a < 8; a++) begin
         bus_if.r_en   = 4'hF;
         bus_if.r_addr = {4{a[AW-1:0]}};
         tick();
         checks++;
         if (bus_if.r_data !== '0 || bus_if.r_valid !== 4'hF) begin
            errors++;
            $display("FAIL clear_read addr %0d: r_data=%h r_valid=%h, required 0 and f", a, bus_if.r_data, bus_if.r_valid);
         end
      end
      idle();
   endtask

   task automatic test_strobe();
      do_write(3'd5, 32'hAABB_CCDD, 4'b1111);
      do_write(3'd5, 32'h1122_3344, 4'b0101);
      bus_if.r_en   = 4'b0001;
      bus_if.r_addr = {9'd0, 3'd5};
      tick();
      checks++;
      if (bus_if.r_data[31:0] !== 32'hAA22_CC44 || bus_if.r_valid !== 4'b0001) begin
         errors++;
         $display("FAIL strobe_merge: got %h valid %h, required aa22cc44 valid 1", bus_if.r_data[31:0], bus_if.r_valid);
      end
      idle();
      do_write(3'd5, 32'hFFFF_FFFF, 4'b0000);
      bus_if.r_en   = 4'b0001;
      bus_if.r_addr = {9'd0, 3'd5};
      tick();
      checks++;
      if (bus_if.r_data[31:0] !== 32'hAA22_CC44) begin
         errors++;
         $display("FAIL strobe_zero_noop: got %h, required aa22cc44", bus_if.r_data[31:0]);
      end
      idle();
   endtask

   task automatic test_parallel();
      do_write(3'd1, 32'h10, 4'hF);
      do_write(3'd2, 32'h20, 4'hF);
      do_write(3'd3, 32'h30, 4'hF);
      do_write(3'd4, 32'h40, 4'hF);
      bus_if.r_en   = 4'hF;
      bus_if.r_addr = {3'd1, 3'd2, 3'd3, 3'd4};
      tick();
      checks++;
      if (bus_if.r_data !== {32'h10, 32'h20, 32'h30, 32'h40} || bus_if.r_valid !== 4'hF) begin
         errors++;
         $display("FAIL parallel_read: r_data=%h r_valid=%h, required 00000010000000200000003000000040 f", bus_if.r_data, bus_if.r_valid);
      end
      idle();
      tick();
      checks++;
      if (bus_if.r_data !== {32'h10, 32'h20, 32'h30, 32'h40} || bus_if.r_valid !== 4'h0) begin
         errors++;
         $display("FAIL parallel_hold: r_data=%h r_valid=%h, required held data and valid 0", bus_if.r_data, bus_if.r_valid);
      end
   endtask

   task automatic test_collision();
      logic [31:0] exp_full;
      logic [31:0] exp_part;
`ifdef RAM_BYPASS_EN
      exp_full = 32'h99;
      exp_part = 32'h11;
`else
      exp_full = 32'h55;
      exp_part = 32'h99;
`endif
      do_write(3'd2, 32'h55, 4'hF);
      bus_if.write_enable = 1'b1;
      bus_if.w_addr       = 3'd2;
      bus_if.w_data       = 32'h99;
      bus_if.w_strb       = 4'hF;
      bus_if.r_en         = 4'b0001;
      bus_if.r_addr       = {9'd0, 3'd2};
      tick();
      checks++;
      if (bus_if.r_data[31:0] !== exp_full || bus_if.r_valid[0] !== 1'b1) begin
         errors++;
         $display("FAIL collision_full: got %h, required %h", bus_if.r_data[31:0], exp_full);
      end
      bus_if.write_enable = 1'b0;
      tick();
      checks++;
      if (bus_if.r_data[31:0] !== 32'h99) begin
         errors++;
         $display("FAIL collision_after: got %h, required 00000099", bus_if.r_data[31:0]);
      end
      // Partial-strobe collision: only byte 0 is replaced
      bus_if.write_enable = 1'b1;
      bus_if.w_data       = 32'hAABB_CC11;
      bus_if.w_strb       = 4'b0001;
      tick();
      checks++;
      if (bus_if.r_data[31:0] !== exp_part) begin
         errors++;
         $display("FAIL collision_partial: got %h, required %h", bus_if.r_data[31:0], exp_part);
      end
      bus_if.write_enable = 1'b0;
      tick();
      checks++;
      if (bus_if.r_data[31:0] !== 32'h11) begin
         errors++;
         $display("FAIL collision_partial_after: got %h, required 00000011", bus_if.r_data[31:0]);
      end
      idle();
   endtask

   task automatic test_reset_mid_clear();
      rst_n = 1'b0;
      tick();
      checks++;
      if (bus_if.init_busy !== 1'b1 || bus_if.r_valid !== 4'h0 || bus_if.r_data !== '0) begin
         errors++;
         $display("FAIL rerun_reset: busy=%b r_valid=%h r_data=%h, required 1 0 0", bus_if.init_busy, bus_if.r_valid, bus_if.r_data);
      end
      rst_n = 1'b1;
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      wait_clear("midclear");
      // Address 5 held aa22cc44 before the resets; the restarted sweep must have wiped it
      bus_if.r_en   = 4'b1000;
      bus_if.r_addr = {3'd5, 9'd0};
      tick();
      checks++;
      if (bus_if.r_data[127:96] !== 32'h0 || bus_if.r_valid !== 4'b1000) begin
         errors++;
         $display("FAIL midclear_wiped: got %h valid %h, required 0 valid 8", bus_if.r_data[127:96], bus_if.r_valid);
      end
      idle();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      idle();
      test_reset();
      test_clear();
      test_strobe();
      test_parallel();
      test_collision();
      test_reset_mid_clear();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ram_mport.md
# ram_mport

Parametrised multi-port RAM, the successor to the team's 3-port register RAM. It has one synchronous byte-strobed write port and NUM_RD independent registered read ports with a valid flag. A built-in clear engine zeroes every word after reset. It sits between datapath stages that need a small banked scratch store with deterministic power-up contents.

## Interface
- ADDR_WIDTH, 3: address bits; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 8: word width.
  - Must be a multiple of 8.
  - Derived STRB_W = DATA_WIDTH/8.
- NUM_RD, 2: number of read ports, 1..8.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- write_enable  in  1  write request for this cycle.
- w_addr  in  ADDR_WIDTH  write address.
- w_data  in  DATA_WIDTH  write data.
- w_strb  in  STRB_W  byte enables; bit i covers w_data[8i+7:8i].
- r_en  in  NUM_RD  per-port read request.
- r_addr  in  NUM_RD*ADDR_WIDTH  read addresses; port p uses bits [p*ADDR_WIDTH +: ADDR_WIDTH].
- r_data  out  NUM_RD*DATA_WIDTH  registered read data; port p uses bits [p*DATA_WIDTH +: DATA_WIDTH].
- r_valid  out  NUM_RD  port p's r_data was updated by a read accepted in the previous cycle.
- init_busy  out  1  clear engine active; write and read requests are ignored.

## Operation
States:
- CLEAR: entered on every edge with rst_n=0; clear counter set to 0.
  - Each cycle with rst_n=1 writes all-zero to memory[counter], then increments the counter.
  - After writing address DEPTH-1, the block moves to READY.
- READY: normal operation; stays until reset.

Reset values (registers): r_data=0, r_valid=0, init_busy=1, state=CLEAR, counter=0.

Write (READY only):
- With write_enable=1, byte i of memory[w_addr] takes w_data byte i when w_strb[i]=1; other bytes hold.
- write_enable with w_strb=0 is a no-op.

Read (READY only):
- When r_en[p]=1 at an edge, r_data port p loads memory[r_addr port p] and r_valid[p]=1 for the following cycle.
- When r_en[p]=0, r_data port p holds its last value and r_valid[p]=0.
- Ports are fully independent. Any number of ports may read the same address in the same cycle.

Requests in CLEAR:
- write_enable and r_en are ignored; memory is not written and r_data is not updated.
- r_valid stays 0 and nothing is queued.

Same-cycle read and write to one address: behaviour is set by the configuration macro (see Configuration).

Reset mid-operation:
- Applies at the next edge: the block returns to CLEAR with counter=0, r_valid=0 and r_data=0.
- The full clear restarts from address 0, even if a clear was in progress.

The clear counter is ADDR_WIDTH+1 bits wide, so reaching DEPTH is detectable without wrap.

## Timing
- Read latency: 1 cycle, from the r_en edge to valid r_data/r_valid.
- Write latency: 1 cycle.
  - Without forwarding, a read issued one cycle after a write returns the new data.
- Clear duration: exactly DEPTH cycles after the first edge with rst_n=1.
  - init_busy=1 through those DEPTH cycles.
  - init_busy falls on the edge that writes address DEPTH-1.
  - The first accepted request is therefore sampled on edge DEPTH+1 after reset release.
- Throughput: one write plus NUM_RD reads every cycle, with no stall.

## Configuration
- RAM_BYPASS_EN defined (write-first forwarding):
  - Applies when a read and a write hit the same address on one edge.
  - The read returns the written word merged per w_strb: new bytes where w_strb[i]=1, old bytes elsewhere.
- RAM_BYPASS_EN undefined (read-first):
  - The same read returns the pre-write word; the write still lands.
  - No forwarding logic is present.

## Test plan
- Reset then clear:
  - Stimulus: hold rst_n=0 for 2 cycles, release, ADDR_WIDTH=3.
  - Response: init_busy=1 for 8 cycles then 0; all ports reading addresses 0..7 return 0x00 with r_valid=1 one cycle after each r_en.
- Strobed write (DATA_WIDTH=32):
  - Stimulus: write 0xAABBCCDD with strb 4'b1111 to addr 5; then 0x11223344 with strb 4'b0101 to addr 5; then read addr 5.
  - Response: read returns 0xAA22CC44.
- Parallel reads:
  - Stimulus: NUM_RD=4; write addr 1..4 = 0x10,0x20,0x30,0x40; read ports 0..3 at addr 4,3,2,1 in one cycle.
  - Response: next cycle r_data = 0x40,0x30,0x20,0x10 with r_valid=4'b1111; the cycle after, r_en=0 gives r_valid=0 with data held.
- Collision:
  - Stimulus: addr 2 holds 0x55; write 0x99 to addr 2 while port 0 reads addr 2.
  - Response: r_data0=0x99 with RAM_BYPASS_EN, 0x55 without; a read on the next cycle returns 0x99 in both builds.
- Requests during clear:
  - Stimulus: write 0xFF to addr 0 and set r_en=1 during CLEAR.
  - Response: r_valid stays 0; after clear, addr 0 reads 0x00.
- Reset mid-clear:
  - Stimulus: assert rst_n=0 after 3 clear cycles, then release.
  - Response: init_busy=1 for a full 8 further cycles; r_data=0 and r_valid=0 throughout.
